// File: rtl/str_cursor_reader.sv
// Byte-string store with a signed cursor answering SV-style s[++p]/s[p--] index commands.
// Define STR_CURSOR_WRAP_EN to reduce the lookup index modulo the string length instead of returning 0.
module str_cursor_reader #(
    parameter int MAX_LEN = 16,
    parameter int POS_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]    wr_addr,
    input  logic [7:0]                    wr_data,
    input  logic                          len_we,
    input  logic [$clog2(MAX_LEN):0]      len_in,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic signed [POS_W-1:0]       cmd_pos,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [7:0]                    rsp_byte,
    output logic signed [POS_W-1:0]       rsp_pos,
    output logic                          rsp_err
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_READ    = 3'd1;
    localparam logic [2:0] OP_PREINC  = 3'd2;
    localparam logic [2:0] OP_POSTINC = 3'd3;
    localparam logic [2:0] OP_PREDEC  = 3'd4;
    localparam logic [2:0] OP_POSTDEC = 3'd5;

    localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               mem [MAX_LEN];
    logic [LW-1:0]            len_q;
    logic signed [POS_W-1:0]  len_s;
    logic signed [POS_W-1:0]  pos_q;
    logic signed [POS_W-1:0]  pos_nxt;
    logic signed [POS_W-1:0]  idx;
    logic                     rsvd;
    logic                     hit;
    logic [AW-1:0]            addr;
    logic [7:0]               byte_sel;
    logic                     accept;

    logic [7:0]               byte_p1;
    logic signed [POS_W-1:0]  pos_p1;
    logic                     err_p1;

`ifdef STR_CURSOR_WRAP_EN
    logic signed [POS_W-1:0]  div;
    logic signed [POS_W-1:0]  rem;
`endif

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] v);
        return (v > LW'(MAX_LEN)) ? LW'(MAX_LEN) : v;
    endfunction

    function automatic logic in_range(input logic signed [POS_W-1:0] i,
                                      input logic signed [POS_W-1:0] n);
        return !i[POS_W-1] && (i < n);
    endfunction

    assign len_s     = $signed({{(POS_W-LW){1'b0}}, len_q});
    assign rsp_valid = (state_q == FULL);
    assign cmd_ready = (state_q == EMPTY) || rsp_ready;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Index and next-cursor selection; reserved ops behave as READ.
    always_comb begin
        idx     = pos_q;
        pos_nxt = pos_q;
        rsvd    = 1'b0;
        case (cmd_op)
            OP_LOAD:    begin idx = cmd_pos;     pos_nxt = cmd_pos;     end
            OP_READ:    begin idx = pos_q;       pos_nxt = pos_q;       end
            OP_PREINC:  begin idx = pos_q + ONE; pos_nxt = pos_q + ONE; end
            OP_POSTINC: begin idx = pos_q;       pos_nxt = pos_q + ONE; end
            OP_PREDEC:  begin idx = pos_q - ONE; pos_nxt = pos_q - ONE; end
            OP_POSTDEC: begin idx = pos_q;       pos_nxt = pos_q - ONE; end
            default:    rsvd = 1'b1;
        endcase
    end

    always_comb begin
        hit  = 1'b0;
        addr = '0;
`ifdef STR_CURSOR_WRAP_EN
        div  = (len_q == '0) ? ONE : len_s;
        rem  = idx % div;
        if (rem < 0) rem = rem + div;
        hit  = (len_q != '0);
        addr = rem[AW-1:0];
`else
        hit  = in_range(idx, len_s);
        addr = idx[AW-1:0];
`endif
    end

    // Sampled before this edge's write lands, giving read-before-write.
    assign byte_sel = hit ? mem[addr] : 8'd0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Stage p1: response register and cursor/length state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pos_q   <= '0;
            len_q   <= '0;
            byte_p1 <= '0;
            pos_p1  <= '0;
            err_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (len_we) len_q <= clamp_len(len_in);
            if (accept) begin
                pos_q   <= pos_nxt;
                byte_p1 <= byte_sel;
                pos_p1  <= pos_nxt;
                err_p1  <= !hit || rsvd;
            end
        end
    end

    assign rsp_byte = byte_p1;
    assign rsp_pos  = pos_p1;
    assign rsp_err  = err_p1;

endmodule

// File: tb/tb_str_cursor_reader.sv
// Self-checking bench for str_cursor_reader: directed scenarios plus randomized commands vs a reference model.
module tb_str_cursor_reader;

    localparam int MAX_LEN = 16;
    localparam int POS_W   = 32;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     wr_en = 1'b0;
    logic [3:0]               wr_addr = '0;
    logic [7:0]               wr_data = '0;
    logic                     len_we = 1'b0;
    logic [4:0]               len_in = '0;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [2:0]               cmd_op = '0;
    logic signed [POS_W-1:0]  cmd_pos = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b1;
    logic [7:0]               rsp_byte;
    logic signed [POS_W-1:0]  rsp_pos;
    logic                     rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_mem [MAX_LEN];
    int m_len = 0;
    int m_pos = 0;

    str_cursor_reader #(.MAX_LEN(MAX_LEN), .POS_W(POS_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_we(len_we), .len_in(len_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pos(cmd_pos),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_byte(rsp_byte), .rsp_pos(rsp_pos), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    // SV string indexing semantics computed directly from the op definitions.
    function automatic void model_cmd(input int op, input int cpos,
                                      output int eb, output int epos, output bit eerr);
        int idx;
        int np;
        int r;
        idx = m_pos;
        np  = m_pos;
        case (op)
            0: begin idx = cpos;      np = cpos;      end
            2: begin idx = m_pos + 1; np = m_pos + 1; end
            3: begin idx = m_pos;     np = m_pos + 1; end
            4: begin idx = m_pos - 1; np = m_pos - 1; end
            5: begin idx = m_pos;     np = m_pos - 1; end
            default: begin idx = m_pos; np = m_pos; end
        endcase
`ifdef STR_CURSOR_WRAP_EN
        if (m_len == 0) begin
            eb = 0; eerr = 1'b1;
        end else begin
            r = idx % m_len;
            if (r < 0) r = r + m_len;
            eb = m_mem[r]; eerr = 1'b0;
        end
`else
        if (idx >= 0 && idx < m_len) begin
            eb = m_mem[idx]; eerr = 1'b0;
        end else begin
            eb = 0; eerr = 1'b1;
        end
`endif
        if (op >= 6) eerr = 1'b1;
        m_pos = np;
        epos  = np;
    endfunction

    task automatic do_cmd(input int op, input int cpos,
                          input bit wen, input int waddr, input int wdata,
                          input bit lwe, input int lval,
                          output int eb, output int epos, output bit eerr);
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_pos = cpos;
        wr_en = wen; wr_addr = waddr[3:0]; wr_data = wdata[7:0];
        len_we = lwe; len_in = lval[4:0];
        model_cmd(op, cpos, eb, epos, eerr);
        if (wen) m_mem[waddr] = wdata;
        if (lwe) m_len = (lval > MAX_LEN) ? MAX_LEN : lval;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; wr_en = 1'b0; len_we = 1'b0;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = i[3:0]; wr_data = s[i];
            len_we = (i == s.len() - 1); len_in = s.len();
            m_mem[i] = s[i];
            @(posedge clk);
            #1;
            wr_en = 1'b0; len_we = 1'b0;
        end
        m_len = s.len();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got %0d want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_byte !== 8'd0) $display("FAIL reset_byte got %0d want 0", rsp_byte); else n_pass++;
        n_checks++; if (rsp_pos !== 0) $display("FAIL reset_pos got %0d want 0", rsp_pos); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err got %0d want 0", rsp_err); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %0d want 1", cmd_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        m_pos = 0; m_len = 0;
    endtask

    task automatic test_basic_ops();
        int eb, ep; bit ee;
        load_str("abcd");
        do_cmd(0, 3, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(4, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h63 || rsp_pos !== 2 || rsp_err !== 1'b0)
            $display("FAIL predec got %h/%0d/%0d want 63/2/0", rsp_byte, rsp_pos, rsp_err); else n_pass++;
        do_cmd(0, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(2, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h62 || rsp_pos !== 1 || rsp_err !== 1'b0)
            $display("FAIL preinc got %h/%0d/%0d want 62/1/0", rsp_byte, rsp_pos, rsp_err); else n_pass++;
        do_cmd(0, 3, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(5, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h64 || rsp_pos !== 2 || rsp_err !== 1'b0)
            $display("FAIL postdec got %h/%0d/%0d want 64/2/0", rsp_byte, rsp_pos, rsp_err); else n_pass++;
        do_cmd(0, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(3, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h61 || rsp_pos !== 1 || rsp_err !== 1'b0)
            $display("FAIL postinc got %h/%0d/%0d want 61/1/0", rsp_byte, rsp_pos, rsp_err); else n_pass++;
    endtask

    task automatic test_range();
        int eb, ep; bit ee;
        logic [7:0] wb; logic we;
        do_cmd(0, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(4, 0, 0, 0, 0, 0, 0, eb, ep, ee);
`ifdef STR_CURSOR_WRAP_EN
        wb = 8'h64; we = 1'b0;
`else
        wb = 8'h00; we = 1'b1;
`endif
        n_checks++; if (rsp_byte !== wb || rsp_pos !== -1 || rsp_err !== we)
            $display("FAIL neg_index got %h/%0d/%0d want %h/-1/%0d", rsp_byte, rsp_pos, rsp_err, wb, we); else n_pass++;
        do_cmd(0, 4, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(1, 0, 0, 0, 0, 0, 0, eb, ep, ee);
`ifdef STR_CURSOR_WRAP_EN
        wb = 8'h61; we = 1'b0;
`else
        wb = 8'h00; we = 1'b1;
`endif
        n_checks++; if (rsp_byte !== wb || rsp_pos !== 4 || rsp_err !== we)
            $display("FAIL idx_eq_len got %h/%0d/%0d want %h/4/%0d", rsp_byte, rsp_pos, rsp_err, wb, we); else n_pass++;
        do_cmd(0, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(2, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_pos !== 32'sh8000_0000 || rsp_byte !== wb || rsp_err !== we)
            $display("FAIL pos_wrap got %h/%h/%0d want 80000000/%h/%0d", rsp_pos, rsp_byte, rsp_err, wb, we); else n_pass++;
        do_cmd(0, 1, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(6, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h62 || rsp_pos !== 1 || rsp_err !== 1'b1)
            $display("FAIL reserved6 got %h/%0d/%0d want 62/1/1", rsp_byte, rsp_pos, rsp_err); else n_pass++;
        do_cmd(7, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h62 || rsp_pos !== 1 || rsp_err !== 1'b1)
            $display("FAIL reserved7 got %h/%0d/%0d want 62/1/1", rsp_byte, rsp_pos, rsp_err); else n_pass++;
    endtask

    task automatic test_backpressure();
        int eb, ep; bit ee;
        do_cmd(0, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain got %0d want 0", rsp_valid); else n_pass++;
        cmd_valid = 1'b1; cmd_op = 3'd3; rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_byte !== 8'h61 || rsp_pos !== 1)
                $display("FAIL bp_hold%0d got rdy=%0d vld=%0d %h/%0d want 0/1 61/1", k, cmd_ready, rsp_valid, rsp_byte, rsp_pos);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_byte !== 8'(8'h61 + k) || rsp_pos !== k + 1)
                $display("FAIL bp_stream%0d got %0d %h/%0d want 1 %h/%0d", k, rsp_valid, rsp_byte, rsp_pos, 8'(8'h61 + k), k + 1);
            else n_pass++;
        end
        cmd_valid = 1'b0;
        m_pos = 4;
        @(posedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_final_drain got %0d want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_same_cycle_write();
        int eb, ep; bit ee;
        logic [7:0] wb; logic we;
        do_cmd(0, 1, 0, 0, 0, 0, 0, eb, ep, ee);
        do_cmd(1, 0, 1, 1, 8'h7A, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h62) $display("FAIL rbw_old got %h want 62", rsp_byte); else n_pass++;
        do_cmd(1, 0, 0, 0, 0, 1, 1, eb, ep, ee);
        n_checks++; if (rsp_byte !== 8'h7A || rsp_err !== 1'b0)
            $display("FAIL rbw_new got %h/%0d want 7a/0", rsp_byte, rsp_err); else n_pass++;
        do_cmd(1, 0, 0, 0, 0, 0, 0, eb, ep, ee);
`ifdef STR_CURSOR_WRAP_EN
        wb = 8'h61; we = 1'b0;
`else
        wb = 8'h00; we = 1'b1;
`endif
        n_checks++; if (rsp_byte !== wb || rsp_err !== we)
            $display("FAIL len_next got %h/%0d want %h/%0d", rsp_byte, rsp_err, wb, we); else n_pass++;
    endtask

    task automatic test_random();
        int eb, ep; bit ee;
        int op, cp, wa, wd, lv;
        bit wen, lwe;
        for (int i = 0; i < MAX_LEN; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = i[3:0]; wr_data = 8'($urandom_range(1, 255));
            m_mem[i] = wr_data;
            @(posedge clk);
            #1;
            wr_en = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            op  = $urandom_range(0, 7);
            cp  = ($urandom_range(0, 9) == 0) ? int'($urandom) : $urandom_range(0, 40) - 20;
            wen = ($urandom_range(0, 3) == 0);
            wa  = $urandom_range(0, MAX_LEN - 1);
            wd  = $urandom_range(0, 255);
            lwe = ($urandom_range(0, 9) == 0);
            lv  = $urandom_range(0, 31);
            do_cmd(op, cp, wen, wa, wd, lwe, lv, eb, ep, ee);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_byte !== 8'(eb) || rsp_pos !== ep || rsp_err !== ee)
                $display("FAIL rand%0d op=%0d got %0d %h/%0d/%0d want 1 %h/%0d/%0d",
                         n, op, rsp_valid, rsp_byte, rsp_pos, rsp_err, 8'(eb), ep, ee);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int eb, ep; bit ee;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; rsp_ready = 1'b0;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rst_pre got %0d want 1", rsp_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_pos !== 0)
            $display("FAIL rst_async got %0d/%0d want 0/0", rsp_valid, rsp_pos); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        m_pos = 0; m_len = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_quiet got %0d want 0", rsp_valid); else n_pass++;
        do_cmd(1, 0, 0, 0, 0, 0, 0, eb, ep, ee);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_pos !== 0 || rsp_byte !== 8'h00 || rsp_err !== 1'b1)
            $display("FAIL rst_read got %0d %h/%0d/%0d want 1 00/0/1", rsp_valid, rsp_byte, rsp_pos, rsp_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_range();
        test_backpressure();
        test_same_cycle_write();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
